// File: rtl/daisy_chain_slave_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | daisy_chain_pkg                                                      |
// | Shared types and constants for the SPI daisy-chain slave node.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package daisy_chain_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int   DC_WIDTH    = 8;

  localparam logic c_SCLK_IDLE = 1'b0;
  localparam logic c_CS_IDLE   = 1'b1;
  localparam logic c_SDO_IDLE  = 1'b0;

endpackage : daisy_chain_pkg
`default_nettype wire

// File: rtl/daisy_chain_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | daisy_chain_slave_if                                                 |
// | SPI chain pins plus parallel result port of one daisy-chain slave.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
interface daisy_chain_slave_if
  import daisy_chain_pkg::*;
#(
  parameter int WIDTH = DC_WIDTH
);

  logic             sclk;
  logic             cs;
  logic             sdi;
  logic             sdo;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             frame_err;

  modport master (
    output sclk, cs, sdi, din,
    input  sdo, dout, dout_valid, frame_err
  );

  modport slave (
    input  sclk, cs, sdi, din,
    output sdo, dout, dout_valid, frame_err
  );

endinterface : daisy_chain_slave_if
`default_nettype wire

// File: rtl/daisy_chain_slave_spi_in_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_in_sync                                                          |
// | Multi-flop synchroniser with rise/fall detection on the synced level.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module spi_in_sync
  import daisy_chain_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = c_SCLK_IDLE
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule : spi_in_sync
`default_nettype wire

// File: rtl/daisy_chain_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | daisy_chain_slave                                                    |
// | WIDTH-bit SPI delay-line node; presents last WIDTH bits at frame end.|
// | Option: DAISY_SLAVE_PRELOAD_EN loads din into the shifter at cs fall.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module daisy_chain_slave
  import daisy_chain_pkg::*;
#(
  parameter int WIDTH       = DC_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  daisy_chain_slave_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic sdi_s;
  logic unused_sclk_lvl, unused_cs_lvl, unused_sdi_rise, unused_sdi_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(c_SCLK_IDLE)) u_sync_sclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.sclk),
    .q_o    (unused_sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // cs resets low so a cs already low at reset release produces no fall edge.
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.cs),
    .q_o    (unused_cs_lvl),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.sdi),
    .q_o    (sdi_s),
    .rise_o (unused_sdi_rise),
    .fall_o (unused_sdi_fall)
  );

  logic [WIDTH-1:0] load_val;

`ifdef DAISY_SLAVE_PRELOAD_EN
  assign load_val = bus.din;
`else
  logic unused_din;
  assign load_val   = '0;
  assign unused_din = ^bus.din;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] dout_q;
  logic [CW-1:0]    cnt_q;
  logic             sdo_q;
  logic             valid_q;
  logic             err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      sdo_q   <= c_SDO_IDLE;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sdo_q <= c_SDO_IDLE;
          if (cs_fall) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
            shreg_q <= load_val;
            sdo_q   <= load_val[0];
          end
        end
        ACTIVE: begin
          // A cs rise wins over any sclk edge seen in the same cycle.
          if (cs_rise) begin
            state_q <= DONE;
          end else begin
            if (sclk_fall) begin
              shreg_q <= {sdi_s, shreg_q[WIDTH-1:1]};
              if (cnt_q != CW'(WIDTH))
                cnt_q <= cnt_q + CW'(1);
            end
            if (sclk_rise)
              sdo_q <= shreg_q[0];
          end
        end
        DONE: begin
          dout_q  <= shreg_q;
          valid_q <= 1'b1;
          err_q   <= (cnt_q < CW'(WIDTH));
          sdo_q   <= c_SDO_IDLE;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sdo        = sdo_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = err_q;

endmodule : daisy_chain_slave
`default_nettype wire

// File: tb/tb_daisy_chain_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_daisy_chain_slave                                                 |
// | Directed bench: two chained slaves driven by a modelled SPI master.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_daisy_chain_slave;
  import daisy_chain_pkg::*;

  localparam int W  = 8;
  localparam int SS = 2;
`ifdef DAISY_SLAVE_PRELOAD_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         sclk = c_SCLK_IDLE;
  logic         cs   = c_CS_IDLE;
  logic         sdi  = 1'b0;
  logic [W-1:0] din1 = '0;
  logic [W-1:0] din2 = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int nv1     = 0;
  int nv2     = 0;

  daisy_chain_slave_if #(.WIDTH(W)) if1 ();
  daisy_chain_slave_if #(.WIDTH(W)) if2 ();

  assign if1.sclk = sclk;
  assign if1.cs   = cs;
  assign if1.sdi  = sdi;
  assign if1.din  = din1;
  assign if2.sclk = sclk;
  assign if2.cs   = cs;
  assign if2.sdi  = if1.sdo;
  assign if2.din  = din2;

  daisy_chain_slave #(.WIDTH(W), .SYNC_STAGES(SS)) u_s1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  daisy_chain_slave #(.WIDTH(W), .SYNC_STAGES(SS)) u_s2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (if1.dout_valid === 1'b1) nv1++;
    if (if2.dout_valid === 1'b1) nv2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame_start();
    @(negedge clk);
    cs = 1'b0;
    wait_clk(6);
  endtask

  // One 8-clk bit period: sdi changes with sclk rise, sdo sampled just before the fall.
  task automatic send_bit(input logic b, output logic so1, output logic so2);
    @(negedge clk);
    sdi  = b;
    sclk = 1'b1;
    wait_clk(3);
    so1 = if1.sdo;
    so2 = if2.sdo;
    wait_clk(1);
    sclk = 1'b0;
    wait_clk(3);
  endtask

  task automatic send_byte(input logic [W-1:0] v, output logic [W-1:0] s1, output logic [W-1:0] s2);
    logic a, b;
    for (int i = 0; i < W; i++) begin
      send_bit(v[i], a, b);
      s1[i] = a;
      s2[i] = b;
    end
  endtask

  task automatic end_frame(input string tag, input logic sclk_too);
    @(negedge clk);
    cs = 1'b1;
    if (sclk_too) sclk = 1'b1;
    wait_clk(3);
    check({tag, "_valid_early"}, if1.dout_valid, 1'b0);
    wait_clk(1);
    check({tag, "_valid_latency"}, if1.dout_valid, 1'b1);
    wait_clk(4);
    sclk = c_SCLK_IDLE;
    wait_clk(2);
  endtask

  initial begin
    logic [W-1:0] s1a, s2a, s1b, s2b;
    logic         a, b;
    int           base1, base2, bad;

    // Reset state
    wait_clk(3);
    check("rst_sdo",   if1.sdo, 1'b0);
    check("rst_dout",  if1.dout, 8'h00);
    check("rst_valid", if1.dout_valid, 1'b0);
    check("rst_err",   if1.frame_err, 1'b0);
    rst = 1'b0;
    wait_clk(8);
    check("post_rst_no_valid", nv1, 0);

    // Preload response word, master sends 0xA5
    din1  = 8'h3C;
    base1 = nv1;
    frame_start();
    send_byte(8'hA5, s1a, s2a);
    end_frame("t1", 1'b0);
    check("t1_sdo",    s1a, PRE ? 8'h3C : 8'h00);
    check("t1_dout",   if1.dout, 8'hA5);
    check("t1_err",    if1.frame_err, 1'b0);
    check("t1_pulses", nv1 - base1, 1);
    check("t1_dout2",  if2.dout, PRE ? 8'h3C : 8'h00);
    din1 = 8'h00;

    // Two chained slaves, 16 bits: 0x5A then 0xC3
    base2 = nv2;
    frame_start();
    send_byte(8'h5A, s1a, s2a);
    send_byte(8'hC3, s1b, s2b);
    end_frame("t2", 1'b0);
    check("t2_dout1",  if1.dout, 8'hC3);
    check("t2_dout2",  if2.dout, 8'h5A);
    check("t2_sdo1_a", s1a, 8'h00);
    check("t2_sdo1_b", s1b, 8'h5A);
    check("t2_sdo2_a", s2a, 8'h00);
    check("t2_sdo2_b", s2b, 8'h00);
    check("t2_err1",   if1.frame_err, 1'b0);
    check("t2_err2",   if2.frame_err, 1'b0);
    check("t2_pulses2", nv2 - base2, 1);

    // Short frame: 5 ones
    base1 = nv1;
    frame_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1, a, b);
    end_frame("t3", 1'b0);
    check("t3_dout",   if1.dout, 8'hF8);
    check("t3_err",    if1.frame_err, 1'b1);
    check("t3_pulses", nv1 - base1, 1);
    check("t3_dout2",  if2.dout, 8'h00);
    check("t3_err2",   if2.frame_err, 1'b1);

    // sclk toggling with cs held high
    base1 = nv1;
    bad   = 0;
    for (int i = 0; i < 20; i++) begin
      send_bit(i[0], a, b);
      if (a !== 1'b0) bad++;
    end
    wait_clk(6);
    check("t4_sdo_idle",  bad, 0);
    check("t4_no_valid",  nv1 - base1, 0);
    check("t4_dout_hold", if1.dout, 8'hF8);
    check("t4_err_hold",  if1.frame_err, 1'b1);

    // Reset mid-frame, cs still low after release
    frame_start();
    for (int i = 0; i < 4; i++) send_bit(1'b1, a, b);
    @(negedge clk);
    rst = 1'b1;
    wait_clk(2);
    check("t5_sdo",   if1.sdo, 1'b0);
    check("t5_dout",  if1.dout, 8'h00);
    check("t5_valid", if1.dout_valid, 1'b0);
    check("t5_err",   if1.frame_err, 1'b0);
    rst   = 1'b0;
    base1 = nv1;
    send_byte(8'hFF, s1a, s2a);
    @(negedge clk);
    cs = 1'b1;
    wait_clk(10);
    check("t5_no_valid",   nv1 - base1, 0);
    check("t5_dout_clear", if1.dout, 8'h00);
    frame_start();
    send_byte(8'h81, s1a, s2a);
    end_frame("t5", 1'b0);
    check("t5_dout_new", if1.dout, 8'h81);
    check("t5_err_new",  if1.frame_err, 1'b0);
    check("t5_pulses",   nv1 - base1, 1);

    // cs rise coincident with an sclk rising edge
    frame_start();
    send_byte(8'h96, s1a, s2a);
    end_frame("t6", 1'b1);
    check("t6_dout", if1.dout, 8'h96);
    check("t6_err",  if1.frame_err, 1'b0);
    check("t6_sdo",  if1.sdo, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_daisy_chain_slave
`default_nettype wire
